// File: rtl/mem_bus_sched.sv
// mem_bus_sched: owner of the shared memory bus between I-cache and D-cache
// refill engines; D-cache priority, starvation guard, turnaround, timeout.
module mem_bus_sched #(
  parameter int ADDR_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_we,
  output logic              dc_grant,
  output logic              dc_done,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  input  logic              bus_ack,
  input  logic              bus_last,
  output logic              timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          acked_q, acked_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic own;
  logic own_req;
  logic fin;
  logic tmo_hit;

  // Grants decode straight from the state register; no req->grant path.
  assign ic_grant = (state_q == GNT_I);
  assign dc_grant = (state_q == GNT_D);
  assign own      = ic_grant | dc_grant;
  assign own_req  = ic_grant ? ic_req : dc_req;

  assign bus_req  = own & ~acked_q;
  assign bus_we   = dc_grant & dc_we;
  assign bus_addr = ic_grant ? ic_addr :
                    dc_grant ? dc_addr : '0;

  // Ack and last in the same cycle also completes the transaction.
  assign fin     = own & (acked_q | bus_ack) & bus_last;
  assign tmo_hit = own & acked_q & ~bus_last & (tmo_cnt_q == T_MAX);

  assign ic_done     = ic_grant & (fin | tmo_hit);
  assign dc_done     = dc_grant & (fin | tmo_hit);
  assign timeout_err = tmo_hit;

  // Next-state: arbitration, ack tracking, timeout and starvation counts.
  always_comb begin
    state_d      = state_q;
    acked_d      = acked_q;
    tmo_cnt_d    = tmo_cnt_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!ic_req) starve_cnt_d = '0;
        if (ic_req && (starve_cnt_q == S_MAX || !dc_req)) begin
          state_d      = GNT_I;
          starve_cnt_d = '0;
          acked_d      = 1'b0;
          tmo_cnt_d    = '0;
        end else if (dc_req) begin
          state_d   = GNT_D;
          acked_d   = 1'b0;
          tmo_cnt_d = '0;
          if (ic_req && starve_cnt_q != S_MAX)
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end
      GNT_I, GNT_D: begin
        if (fin || tmo_hit) begin
          state_d = TURN;
        end else if (!acked_q) begin
          if (bus_ack) begin
            acked_d   = 1'b1;
            tmo_cnt_d = TW'(1);
          end else if (!own_req) begin
            state_d = TURN;
          end
        end else if (tmo_cnt_q != T_MAX) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      TURN: begin
        state_d   = IDLE;
        acked_d   = 1'b0;
        tmo_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acked_q      <= 1'b0;
      tmo_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      acked_q      <= acked_d;
      tmo_cnt_q    <= tmo_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_sched.sv
// tb_mem_bus_sched: directed vector table plus hand sequences for
// reset behaviour of mem_bus_sched (STARVE_LIMIT=4, TIMEOUT=8).
module tb_mem_bus_sched;

  localparam int AW = 64;
  localparam logic [AW-1:0] IC_A = 64'h0000_0000_0000_1040;
  localparam logic [AW-1:0] DC_A = 64'h0000_0000_0000_2080;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we, bus_ack, bus_last;
  logic [AW-1:0] ic_addr, dc_addr, bus_addr;
  logic          ic_grant, ic_done, dc_grant, dc_done;
  logic          bus_req, bus_we, timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  // in: {ir,dr,we,ack,last}; exp: {ig,dg,br,bw,idn,ddn,te}
  typedef struct {
    logic [4:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  mem_bus_sched #(
    .ADDR_W(AW),
    .STARVE_LIMIT(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ic_req(ic_req),
    .ic_addr(ic_addr),
    .ic_grant(ic_grant),
    .ic_done(ic_done),
    .dc_req(dc_req),
    .dc_addr(dc_addr),
    .dc_we(dc_we),
    .dc_grant(dc_grant),
    .dc_done(dc_done),
    .bus_req(bus_req),
    .bus_addr(bus_addr),
    .bus_we(bus_we),
    .bus_ack(bus_ack),
    .bus_last(bus_last),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {ic_grant, dc_grant, bus_req, bus_we,
            ic_done, dc_done, timeout_err};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] in, input logic [6:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] in);
    {ic_req, dc_req, dc_we, bus_ack, bus_last} = in;
  endtask

  initial begin
    logic [AW-1:0] ea;
    ic_addr = IC_A;
    dc_addr = DC_A;

    // D only: ack in cycle 2, last in cycle 6
    add(5'b01100, 7'b0000000);
    add(5'b01100, 7'b0111000);
    add(5'b01110, 7'b0111000);
    add(5'b00100, 7'b0101000);
    add(5'b00100, 7'b0101000);
    add(5'b00100, 7'b0101000);
    add(5'b00101, 7'b0101010);
    add(5'b00000, 7'b0000000);
    add(5'b00000, 7'b0000000);
    // I only: last before ack ignored, then ack+last together
    add(5'b10000, 7'b0000000);
    add(5'b10001, 7'b1010000);
    add(5'b10011, 7'b1010100);
    add(5'b10000, 7'b0000000);
    add(5'b00000, 7'b0000000);
    // I withdraws before ack
    add(5'b10000, 7'b0000000);
    add(5'b00000, 7'b1010000);
    add(5'b00000, 7'b0000000);
    add(5'b00000, 7'b0000000);
    add(5'b00000, 7'b0000000);
    // D acked, no last: timeout 8 cycles after ack
    add(5'b01000, 7'b0000000);
    add(5'b01010, 7'b0110000);
    for (int k = 0; k < 7; k++) add(5'b01000, 7'b0100000);
    add(5'b01000, 7'b0100011);
    add(5'b00000, 7'b0000000);
    add(5'b00000, 7'b0000000);
    // both held: D,D,D,D,I,D
    for (int k = 0; k < 4; k++) begin
      add(5'b11111, 7'b0000000);
      add(5'b11111, 7'b0111010);
      add(5'b11111, 7'b0000000);
    end
    add(5'b11111, 7'b0000000);
    add(5'b11111, 7'b1010100);
    add(5'b11111, 7'b0000000);
    add(5'b11111, 7'b0000000);
    add(5'b11111, 7'b0111010);
    add(5'b11111, 7'b0000000);

    // reset held with every request high
    reset = 1'b1;
    drive(5'b11111);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", 64'(outs()), 64'd0);
    chk("rst_addr", bus_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(5'b11000);
    #1;
    chk("rel_idle", 64'(outs()), 64'd0);
    @(negedge clk);
    #1;
    chk("rel_dgnt", 64'(outs()), 64'(7'b0110000));
    chk("rel_addr", bus_addr, DC_A);
    reset = 1'b1;
    drive(5'b00000);
    #1;
    chk("rst2_outs", 64'(outs()), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].in);
      #1;
      chk($sformatf("vec%0d_outs", i), 64'(outs()), 64'(vecs[i].exp));
      ea = vecs[i].exp[6] ? IC_A : vecs[i].exp[5] ? DC_A : '0;
      chk($sformatf("vec%0d_addr", i), bus_addr, ea);
    end

    // reset mid post-ack drops everything without waiting for a clock
    @(negedge clk);
    drive(5'b01000);
    #1;
    chk("mr_idle", 64'(outs()), 64'd0);
    @(negedge clk);
    drive(5'b01010);
    #1;
    chk("mr_pre", 64'(outs()), 64'(7'b0110000));
    @(negedge clk);
    drive(5'b01000);
    #1;
    chk("mr_post", 64'(outs()), 64'(7'b0100000));
    #2;
    reset = 1'b1;
    #1;
    chk("mr_async", 64'(outs()), 64'd0);
    chk("mr_addr", bus_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_rel", 64'(outs()), 64'd0);
    @(negedge clk);
    #1;
    chk("mr_resume", 64'(outs()), 64'(7'b0110000));
    chk("mr_raddr", bus_addr, DC_A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
